rf_wb_ctrl: RTL and testbench
=============================

Name: rf_wb_ctrl

Overview:
- Write-back controller for the 32x32 register file, which has one write port.
- Arbitrates the two write-back sources (0 = ALU, 1 = load unit) onto that port with round-robin fairness, registering the winning write one cycle before the RF write.
- Holds a pending-write scoreboard (one busy bit per register) that the issue stage marks and queries for RAW/WAW stalls.

Parameters:
ADDR_WIDTH, 5, register address width
WORD_WIDTH, 32, data word width
REG_DEPTH, 32, number of registers (2**ADDR_WIDTH)

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
wb0_valid  input  1  source 0 write request
wb0_addr  input  ADDR_WIDTH  source 0 destination register
wb0_data  input  WORD_WIDTH  source 0 write data
wb0_ready  output  1  source 0 request accepted this cycle
wb1_valid  input  1  source 1 write request
wb1_addr  input  ADDR_WIDTH  source 1 destination register
wb1_data  input  WORD_WIDTH  source 1 write data
wb1_ready  output  1  source 1 request accepted this cycle
rf_wr_en  output  1  to RF wr_en, registered
rf_wr_addr  output  ADDR_WIDTH  to RF wr_addr, registered
rf_wr_data  output  WORD_WIDTH  to RF wr_data, registered
mark_en  input  1  issue stage: set busy for mark_addr
mark_addr  input  ADDR_WIDTH  destination being issued
q_addrA  input  ADDR_WIDTH  source-A query address
q_addrB  input  ADDR_WIDTH  source-B query address
busyA  output  1  busy[q_addrA], combinational
busyB  output  1  busy[q_addrB], combinational
busy_vec  output  REG_DEPTH  full scoreboard, registered

Behaviour:
- Reset (async, nrst low): rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, busy_vec=0, rr pointer=0. Source 0 has priority on the first contention after reset. A reset mid-transfer discards any write held in the output register, so no RF write occurs.
- Arbitration is combinational; ready does not depend on the other source's ready.
  - Only one valid: grant it.
  - Both valid: grant the source not granted on the last contended accept. The rr pointer updates only on cycles where both are valid.
  - Neither valid: no grant.
  - wbX_ready = grantX. A transfer completes on a clock edge with valid&ready. An ungranted source must hold valid/addr/data stable until accepted.
- Output register loads on every edge:
  - rf_wr_en <= accept && (granted addr != 0).
  - rf_wr_addr/rf_wr_data <= granted addr/data when accepted, otherwise hold.
- Latency: accepted at edge N -> rf_wr_* valid during cycle N..N+1 -> RF written at edge N+1.
- Throughput: one write per cycle. The port never backpressures a lone requester.
- Address 0 requests are accepted (ready=1), generate no RF write, and do not touch the scoreboard.
- Scoreboard update at each edge:
  - clear: if rf_wr_en, busy[rf_wr_addr] <= 0 (cleared when the RF is actually written).
  - set: if mark_en && mark_addr != 0, busy[mark_addr] <= 1.
  - Same address in set and clear on one edge: set wins (new producer issued).
  - Marking an already-busy register leaves it busy. Issue must stall on busy destinations; no outstanding-count tracking.
  - busy[0] is constant 0.
- busyA/busyB read the registered busy_vec; no bypass. A register written at edge N reads not-busy from cycle N onward. The RF's write-then-read timing makes the data available in the same cycle.

Decomposition:
- Shared package holds ADDR_WIDTH, WORD_WIDTH and REG_DEPTH, common with the RF. It also holds localparams SRC_ALU=0 and SRC_MEM=1.
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter (req[1:0], grant[1:0], pointer flop).
- Scoreboard and output register stay in rf_wb_ctrl.

Test Plan:
1. Reset, then wb0 {addr 5, data 0xDEADBEEF} alone -> wb0_ready=1 same cycle; next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF.
2. wb0 {3, 0x11} and wb1 {4, 0x22} both held valid for 4 cycles -> grants alternate 0,1,0,1 (source 0 first after reset); RF writes 3,4,3,4.
3. wb1 {0, 0xFFFF} -> wb1_ready=1, rf_wr_en stays 0, busy_vec unchanged.
4. mark_en addr 7 -> busy_vec[7]=1, q_addrA=7 gives busyA=1. Then wb0 {7, 0x5A} -> busy[7] clears at the RF-write edge and busyA=0 in the following cycle.
5. mark_en addr 9 on the same edge rf_wr_en=1, rf_wr_addr=9 -> busy[9]=1 afterwards. mark_en addr 0 -> busy_vec[0]=0.
6. Accept wb0 {12, 0x77}, then pulse nrst low before the RF-write edge -> rf_wr_en=0, busy_vec=0, no write to register 12; after release, arbitration restarts with source 0 priority.

Source files
------------

// File: rtl/rf_wb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_ctrl_pkg
// Sizes shared between the write-back controller and the 32x32 register file,
// plus the write-back source indices used by the arbiter grant vector.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package rf_wb_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned REG_DEPTH  = 2 ** ADDR_WIDTH;

  // Bit positions in the request/grant vectors.
  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_MEM = 1;

  // A register address that really names a register; x0 is hard-wired.
  function automatic logic is_real_reg(input logic [ADDR_WIDTH-1:0] addr);
    return (addr != {ADDR_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/rf_wb_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a combinational grant.
//   clk, nrst : clock, asynchronous active-low reset
//   req[1:0]  : request per source
//   grant[1:0]: one-hot (or zero) grant, same cycle as req
// A lone requester is always granted. On contention the source that did not
// win the previous contended cycle wins; the pointer only moves on contention.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module rr_arb2
  import rf_wb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // ptr_r = 0 : source 0 wins the next contention, 1 : source 1 wins.
  logic ptr_r;
  logic [1:0] grant_s;
  logic both_s;

  assign both_s = req[SRC_ALU] & req[SRC_MEM];

  // Grant selection: single requester passes straight through.
  always_comb begin
    grant_s = 2'b00;
    if (both_s) begin
      if (ptr_r) begin
        grant_s[SRC_MEM] = 1'b1;
      end else begin
        grant_s[SRC_ALU] = 1'b1;
      end
    end else begin
      grant_s = req;
    end
  end

  // Pointer flips to the loser after every contended cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr_r <= 1'b0;
    end else if (both_s) begin
      ptr_r <= ~ptr_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/rf_wb_ctrl.sv
// ---------------------------------------------------------------------------
// rf_wb_ctrl
// Write-back controller for the single write port of the 32x32 register file,
// with a pending-write scoreboard for the issue stage.
//   clk, nrst                      : clock, asynchronous active-low reset
//   wb0_* (ALU), wb1_* (load unit) : valid/ready write-back requests
//   rf_wr_en/addr/data             : registered RF write port drive
//   mark_en, mark_addr             : issue stage sets busy for a destination
//   q_addrA/B -> busyA/B           : combinational scoreboard lookups
//   busy_vec                       : registered scoreboard (bit 0 always 0)
// An accepted write is held one cycle in the output register and lands in
// the RF at the following edge; that same edge clears the busy bit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  wb0_valid,
  input  logic [ADDR_WIDTH-1:0] wb0_addr,
  input  logic [WORD_WIDTH-1:0] wb0_data,
  output logic                  wb0_ready,
  input  logic                  wb1_valid,
  input  logic [ADDR_WIDTH-1:0] wb1_addr,
  input  logic [WORD_WIDTH-1:0] wb1_data,
  output logic                  wb1_ready,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [WORD_WIDTH-1:0] rf_wr_data,
  input  logic                  mark_en,
  input  logic [ADDR_WIDTH-1:0] mark_addr,
  input  logic [ADDR_WIDTH-1:0] q_addrA,
  input  logic [ADDR_WIDTH-1:0] q_addrB,
  output logic                  busyA,
  output logic                  busyB,
  output logic [REG_DEPTH-1:0]  busy_vec
);

  logic [1:0]            req_s;
  logic [1:0]            grant_s;
  logic                  accept_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [WORD_WIDTH-1:0] sel_data_s;
  logic [REG_DEPTH-1:0]  busy_nxt_s;

  logic                  rf_wr_en_r;
  logic [ADDR_WIDTH-1:0] rf_wr_addr_r;
  logic [WORD_WIDTH-1:0] rf_wr_data_r;
  logic [REG_DEPTH-1:0]  busy_vec_r;

  assign req_s[SRC_ALU] = wb0_valid;
  assign req_s[SRC_MEM] = wb1_valid;

  rr_arb2 u_arb (
    .clk   (clk),
    .nrst  (nrst),
    .req   (req_s),
    .grant (grant_s)
  );

  assign accept_s  = grant_s[SRC_ALU] | grant_s[SRC_MEM];
  assign wb0_ready = grant_s[SRC_ALU];
  assign wb1_ready = grant_s[SRC_MEM];

  // Route the winning source's address/data toward the output register.
  always_comb begin
    sel_addr_s = wb0_addr;
    sel_data_s = wb0_data;
    if (grant_s[SRC_MEM]) begin
      sel_addr_s = wb1_addr;
      sel_data_s = wb1_data;
    end else begin
      sel_addr_s = wb0_addr;
      sel_data_s = wb0_data;
    end
  end

  // Output register: x0 writes are accepted but never reach the RF.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rf_wr_en_r   <= 1'b0;
      rf_wr_addr_r <= {ADDR_WIDTH{1'b0}};
      rf_wr_data_r <= {WORD_WIDTH{1'b0}};
    end else begin
      rf_wr_en_r <= accept_s & is_real_reg(sel_addr_s);
      if (accept_s) begin
        rf_wr_addr_r <= sel_addr_s;
        rf_wr_data_r <= sel_data_s;
      end else begin
        rf_wr_addr_r <= rf_wr_addr_r;
        rf_wr_data_r <= rf_wr_data_r;
      end
    end
  end

  // Scoreboard next state: clear on the actual RF write, then set on issue
  // so a new producer of the same register overrides the retiring one.
  always_comb begin
    busy_nxt_s = busy_vec_r;
    if (rf_wr_en_r) begin
      busy_nxt_s[rf_wr_addr_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (mark_en && is_real_reg(mark_addr)) begin
      busy_nxt_s[mark_addr] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy_vec_r <= {REG_DEPTH{1'b0}};
    end else begin
      busy_vec_r <= busy_nxt_s;
    end
  end

  assign rf_wr_en   = rf_wr_en_r;
  assign rf_wr_addr = rf_wr_addr_r;
  assign rf_wr_data = rf_wr_data_r;
  assign busy_vec   = busy_vec_r;
  // No bypass: a register retiring at this edge reads not-busy from here on.
  assign busyA      = busy_vec_r[q_addrA];
  assign busyB      = busy_vec_r[q_addrB];

endmodule

// File: tb/tb_rf_wb_ctrl.sv
`timescale 1ns/1ps
module tb_rf_wb_ctrl;
  import rf_wb_ctrl_pkg::*;

  logic                  clk;
  logic                  nrst;
  logic                  wb0_valid;
  logic [ADDR_WIDTH-1:0] wb0_addr;
  logic [WORD_WIDTH-1:0] wb0_data;
  logic                  wb0_ready;
  logic                  wb1_valid;
  logic [ADDR_WIDTH-1:0] wb1_addr;
  logic [WORD_WIDTH-1:0] wb1_data;
  logic                  wb1_ready;
  logic                  rf_wr_en;
  logic [ADDR_WIDTH-1:0] rf_wr_addr;
  logic [WORD_WIDTH-1:0] rf_wr_data;
  logic                  mark_en;
  logic [ADDR_WIDTH-1:0] mark_addr;
  logic [ADDR_WIDTH-1:0] q_addrA;
  logic [ADDR_WIDTH-1:0] q_addrB;
  logic                  busyA;
  logic                  busyB;
  logic [REG_DEPTH-1:0]  busy_vec;

  int n_vec;
  int n_err;

  rf_wb_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .wb0_valid  (wb0_valid),
    .wb0_addr   (wb0_addr),
    .wb0_data   (wb0_data),
    .wb0_ready  (wb0_ready),
    .wb1_valid  (wb1_valid),
    .wb1_addr   (wb1_addr),
    .wb1_data   (wb1_data),
    .wb1_ready  (wb1_ready),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .mark_en    (mark_en),
    .mark_addr  (mark_addr),
    .q_addrA    (q_addrA),
    .q_addrB    (q_addrB),
    .busyA      (busyA),
    .busyB      (busyB),
    .busy_vec   (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    nrst      = 1'b0;
    wb0_valid = 1'b0; wb0_addr = 5'd0; wb0_data = 32'd0;
    wb1_valid = 1'b0; wb1_addr = 5'd0; wb1_data = 32'd0;
    mark_en   = 1'b0; mark_addr = 5'd0;
    q_addrA   = 5'd0; q_addrB = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en",   {31'd0, rf_wr_en}, 32'd0);
    chk("rst_addr", {27'd0, rf_wr_addr}, 32'd0);
    chk("rst_data", rf_wr_data, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // 1: lone wb0 request, one-cycle latency to the RF port
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    #1;
    chk("t1_rdy0", {31'd0, wb0_ready}, 32'd1);
    chk("t1_rdy1", {31'd0, wb1_ready}, 32'd0);
    tick();
    wb0_valid = 1'b0;
    chk("t1_en",   {31'd0, rf_wr_en}, 32'd1);
    chk("t1_addr", {27'd0, rf_wr_addr}, 32'd5);
    chk("t1_data", rf_wr_data, 32'hDEADBEEF);

    // 2: sustained contention alternates 0,1,0,1
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h11;
    wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rdy0", {31'd0, wb0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_rdy1", {31'd0, wb1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("t2_en",   {31'd0, rf_wr_en}, 32'd1);
      chk("t2_addr", {27'd0, rf_wr_addr}, (i % 2 == 0) ? 32'd3 : 32'd4);
      chk("t2_data", rf_wr_data, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    wb0_valid = 1'b0;

    // 3: write to x0 is accepted but produces no RF write
    wb1_addr = 5'd0; wb1_data = 32'hFFFF;
    #1;
    chk("t3_rdy1", {31'd0, wb1_ready}, 32'd1);
    tick();
    wb1_valid = 1'b0;
    chk("t3_en",   {31'd0, rf_wr_en}, 32'd0);
    chk("t3_busy", busy_vec, 32'd0);

    // 4: mark 7, then retire it through wb0
    mark_en = 1'b1; mark_addr = 5'd7;
    tick();
    mark_en = 1'b0;
    q_addrA = 5'd7; q_addrB = 5'd5;
    #1;
    chk("t4_vec",   busy_vec, 32'h0000_0080);
    chk("t4_busyA", {31'd0, busyA}, 32'd1);
    chk("t4_busyB", {31'd0, busyB}, 32'd0);
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h5A;
    tick();
    wb0_valid = 1'b0;
    chk("t4_en",    {31'd0, rf_wr_en}, 32'd1);
    chk("t4_hold",  {31'd0, busyA}, 32'd1);
    tick();
    chk("t4_clr",   {31'd0, busyA}, 32'd0);
    chk("t4_vec0",  busy_vec, 32'd0);

    // 5: set and clear of register 9 on the same edge -> set wins; x0 never marks
    wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h99;
    tick();
    wb0_valid = 1'b0;
    chk("t5_en",   {31'd0, rf_wr_en}, 32'd1);
    mark_en = 1'b1; mark_addr = 5'd9;
    tick();
    chk("t5_set",  busy_vec, 32'h0000_0200);
    mark_addr = 5'd0;
    tick();
    mark_en = 1'b0;
    chk("t5_x0",   busy_vec, 32'h0000_0200);

    // 6: contended accept of wb0 {12} (pointer moves to source 1), then reset
    wb0_valid = 1'b1; wb0_addr = 5'd12; wb0_data = 32'h77;
    wb1_valid = 1'b1; wb1_addr = 5'd13; wb1_data = 32'h88;
    #1;
    chk("t6_rdy0", {31'd0, wb0_ready}, 32'd1);
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    chk("t6_addr", {27'd0, rf_wr_addr}, 32'd12);
    #1;
    nrst = 1'b0;
    #1;
    chk("t6_en",   {31'd0, rf_wr_en}, 32'd0);
    chk("t6_busy", busy_vec, 32'd0);
    tick();
    chk("t6_en2",  {31'd0, rf_wr_en}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h33;
    wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h44;
    #1;
    chk("t6_pri0", {31'd0, wb0_ready}, 32'd1);
    chk("t6_pri1", {31'd0, wb1_ready}, 32'd0);
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    chk("t6_wr",   {27'd0, rf_wr_addr}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
